// File: rtl/rf_readout_pkg.sv
// Shared types and default constants for the RF readout sequencer and its tile wrapper.
package rf_readout_pkg;

  localparam int RES_W_DEF      = 10;
  localparam int SETTLE_CYC_DEF = 64;
  localparam int RST_CYC_DEF    = 4;
  localparam int INT_W_DEF      = 8;

  typedef enum logic [2:0] {
    IDLE,
    POWERUP,
    RESET_INT,
    INTEGRATE,
    CONVERT,
    DONE
  } rf_state_e;

endpackage

// File: rtl/rf_readout_sequencer_if.sv
// Host-side control and result bus of the readout sequencer.
// Handshake: a result transfers in any cycle where result_valid and result_ready are both 1;
// result/overflow stay stable while result_valid is high and ready is low.
interface rf_readout_sequencer_if #(
  parameter int RES_W = 10,
  parameter int INT_W = 8
);
  logic             start;
  logic             abort;
  logic             cont;
  logic [INT_W-1:0] int_len;
  logic             result_ready;
  logic             result_valid;
  logic [RES_W-1:0] result;
  logic             overflow;
  logic             busy;

  modport master (
    output start, abort, cont, int_len, result_ready,
    input  result_valid, result, overflow, busy
  );

  modport slave (
    input  start, abort, cont, int_len, result_ready,
    output result_valid, result, overflow, busy
  );
endinterface

// File: rtl/rf_sync2.sv
// Two-flop synchronizer for an asynchronous level, reset to 0.
module rf_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end
endmodule

// File: rtl/rf_readout_sequencer.sv
// Sequences bias settle, integrator reset, integration and single-slope ramp conversion,
// and presents the captured ramp code on a valid/ready bus.
module rf_readout_sequencer
  import rf_readout_pkg::*;
#(
  parameter int RES_W      = RES_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int RST_CYC    = RST_CYC_DEF,
  parameter int INT_W      = INT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  rf_readout_sequencer_if.slave host,
  input  logic                  comp_in,
  output logic                  bias_en,
  output logic                  int_rst,
  output logic                  int_en,
  output logic                  ramp_en,
  output rf_state_e             state_dbg_o
);
  // One down-counter serves all timed states, so it must hold the longest of them.
  localparam int TMR_MAX0 = (SETTLE_CYC > RST_CYC) ? SETTLE_CYC : RST_CYC;
  localparam int TMR_MAX  = (TMR_MAX0 > (1 << INT_W)) ? TMR_MAX0 : (1 << INT_W);
  localparam int TMR_W    = $clog2(TMR_MAX + 1);

  rf_state_e        state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [RES_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             bias_q, int_rst_q, int_en_q, ramp_q, busy_q, vld_q;
  logic             comp_s;

  rf_sync2 u_comp_sync (
    .clk (clk),
    .rst (rst),
    .d_i (comp_in),
    .q_o (comp_s)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (host.start) begin
          state_d = POWERUP;
          tmr_d   = TMR_W'(SETTLE_CYC - 1);
        end
      end
      POWERUP: begin
        if (tmr_q == '0) begin
          state_d = RESET_INT;
          tmr_d   = TMR_W'(RST_CYC - 1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      RESET_INT: begin
        if (tmr_q == '0) begin
          state_d = INTEGRATE;
          tmr_d   = TMR_W'(host.int_len);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      INTEGRATE: begin
        if (tmr_q == '0) begin
          state_d = CONVERT;
          cnt_d   = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      CONVERT: begin
        // A crossing seen on the saturation cycle still counts as a real crossing.
        if (comp_s) begin
          state_d = DONE;
          res_d   = cnt_q;
          ovf_d   = 1'b0;
        end else if (cnt_q == '1) begin
          state_d = DONE;
          res_d   = '1;
          ovf_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + RES_W'(1);
        end
      end
      DONE: begin
        if (vld_q && host.result_ready) begin
          if (host.cont) begin
            state_d = RESET_INT;
            tmr_d   = TMR_W'(RST_CYC - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (host.abort) state_d = IDLE;
  end

  // Outputs are decoded from the next state so every pin is a flop aligned with its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      bias_q    <= 1'b0;
      int_rst_q <= 1'b0;
      int_en_q  <= 1'b0;
      ramp_q    <= 1'b0;
      busy_q    <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
      bias_q    <= (state_d != IDLE);
      int_rst_q <= (state_d == RESET_INT);
      int_en_q  <= (state_d == INTEGRATE);
      ramp_q    <= (state_d == CONVERT);
      busy_q    <= (state_d != IDLE);
      vld_q     <= (state_d == DONE);
    end
  end

  assign bias_en           = bias_q;
  assign int_rst           = int_rst_q;
  assign int_en            = int_en_q;
  assign ramp_en           = ramp_q;
  assign host.busy         = busy_q;
  assign host.result_valid = vld_q;
  assign host.result       = res_q;
  assign host.overflow     = ovf_q;
  assign state_dbg_o       = state_q;
endmodule

// File: tb/tb_rf_readout_sequencer.sv
// Bench for rf_readout_sequencer: per-conversion expected output traces built from phase lengths.
module tb_rf_readout_sequencer;
  import rf_readout_pkg::*;

  localparam int RES_W  = 10;
  localparam int SETTLE = 64;
  localparam int RSTC   = 4;
  localparam int INT_W  = 8;
  localparam int MAXC   = (1 << RES_W) - 1;
  localparam int OBS_W  = 7 + RES_W;

  typedef struct packed {
    logic             bias, irst, ien, ramp, busy, vld, ovf;
    logic [RES_W-1:0] res;
  } obs_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic      comp_in;
  logic      bias_en, int_rst, int_en, ramp_en;
  rf_state_e state_dbg;

  rf_readout_sequencer_if #(.RES_W(RES_W), .INT_W(INT_W)) host ();

  rf_readout_sequencer #(
    .RES_W(RES_W), .SETTLE_CYC(SETTLE), .RST_CYC(RSTC), .INT_W(INT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .host        (host.slave),
    .comp_in     (comp_in),
    .bias_en     (bias_en),
    .int_rst     (int_rst),
    .int_en      (int_en),
    .ramp_en     (ramp_en),
    .state_dbg_o (state_dbg)
  );

  // scoreboard
  logic [OBS_W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pwr_n, irst_n, ien_n, ramp_n;
  logic [RES_W-1:0] cur_res;
  bit               cur_ovf;
  int               abort_at, idx;
  bit               aborted;

  always @(negedge clk) begin
    obs_t a, e;
    cyc++;
    a = {bias_en, int_rst, int_en, ramp_en, host.busy, host.result_valid,
         host.overflow, host.result};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL trace cycle=%0d actual=%h expected=%h", cyc, a, e);
      end
    end
    if (bias_en && !int_rst && !int_en && !ramp_en && !host.result_valid) pwr_n++;
    if (int_rst) irst_n++;
    if (int_en)  ien_n++;
    if (ramp_en) ramp_n++;
  end

  task automatic chk(string nm, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
    end
  endtask

  function automatic obs_t mk(bit b, bit ir, bit ie, bit rp, bit v);
    obs_t o;
    o = {b, ir, ie, rp, b, v, cur_ovf, cur_res};
    return o;
  endfunction

  // driver tasks: inputs are set #1 after the edge, expectation is for the current cycle
  task automatic tick(obs_t e, bit st, bit ab, bit ci, bit rdy, bit cn, logic [INT_W-1:0] il);
    host.start = st; host.abort = ab; comp_in = ci;
    host.result_ready = rdy; host.cont = cn; host.int_len = il;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic btick(obs_t e, bit ci, bit rdy, bit cn, logic [INT_W-1:0] il);
    bit ab;
    ab = (idx == abort_at);
    tick(e, bit'($urandom_range(0, 1)), ab, ci, rdy || ab, cn, il);
    idx++;
    if (ab) aborted = 1'b1;
  endtask

  // k: cycle of CONVERT in which comp_in rises (<0: high from the start)
  task automatic run_conv(int il, int k, int wr, bit cont_hs, bit from_idle, int ab_at,
                          output bit went_cont);
    int r; bit ovf; bit pre; logic [INT_W-1:0] ilv;
    ilv = INT_W'(il);
    if (k < 0)             begin r = 0;     ovf = 1'b0; end
    else if (k + 2 > MAXC) begin r = MAXC;  ovf = 1'b1; end
    else                   begin r = k + 2; ovf = 1'b0; end
    pre = (k < 0);
    idx = 0; aborted = 1'b0; abort_at = ab_at;
    if (from_idle) begin
      tick(mk(0, 0, 0, 0, 0), 1'b1, 1'b0, pre, 1'b0, bit'($urandom_range(0, 1)), ilv);
      for (int i = 0; i < SETTLE && !aborted; i++)
        btick(mk(1, 0, 0, 0, 0), pre, 1'b0, bit'($urandom_range(0, 1)), ilv);
    end
    for (int i = 0; i < RSTC && !aborted; i++)
      btick(mk(1, 1, 0, 0, 0), pre, 1'b0, bit'($urandom_range(0, 1)), ilv);
    for (int i = 0; i <= il && !aborted; i++)
      btick(mk(1, 0, 1, 0, 0), pre, 1'b0, bit'($urandom_range(0, 1)), ilv);
    for (int j = 0; j <= r && !aborted; j++)
      btick(mk(1, 0, 0, 1, 0), pre || (j >= k), 1'b0, bit'($urandom_range(0, 1)),
            INT_W'($urandom));
    if (!aborted) begin cur_res = RES_W'(r); cur_ovf = ovf; end
    for (int j = 0; j <= wr && !aborted; j++)
      btick(mk(1, 0, 0, 0, 1), 1'b0, j == wr,
            (j == wr) ? cont_hs : bit'($urandom_range(0, 1)), ilv);
    if (aborted) tick(mk(0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ilv);
    went_cont = !aborted && cont_hs;
  endtask

  task automatic clr_counts();
    pwr_n = 0; irst_n = 0; ien_n = 0; ramp_n = 0;
  endtask

  initial begin
    bit wc;
    int il, k, wr, len, ab;
    host.start = 0; host.abort = 0; host.cont = 0; host.int_len = '0;
    host.result_ready = 0; comp_in = 0;
    cur_res = '0; cur_ovf = 1'b0; abort_at = -1; idx = 0; aborted = 0;
    clr_counts();
    #1 rst = 1'b1;
    #2;
    chk("reset_outputs", int'({bias_en, int_rst, int_en, ramp_en, host.busy,
        host.result_valid, host.overflow, host.result}), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // abort beats start in IDLE
    tick(mk(0, 0, 0, 0, 0), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick(mk(0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // single shot, crossing 100 cycles into CONVERT
    clr_counts();
    run_conv(9, 100, 3, 1'b0, 1'b1, -1, wc);
    chk("single_result", int'(host.result), 102);
    chk("single_ovf", int'(host.overflow), 0);
    chk("settle_cycles", pwr_n, 64);
    chk("int_rst_cycles", irst_n, 4);
    chk("int_en_cycles", ien_n, 10);
    chk("ramp_cycles", ramp_n, 103);
    chk("single_idle_bias", int'(bias_en), 0);

    // no crossing: full ramp and overflow
    clr_counts();
    run_conv(0, 5000, 0, 1'b0, 1'b1, -1, wc);
    chk("ovf_result", int'(host.result), 1023);
    chk("ovf_flag", int'(host.overflow), 1);
    chk("ovf_ramp_cycles", ramp_n, 1024);

    // comparator already high
    run_conv(2, -1, 1, 1'b0, 1'b1, -1, wc);
    chk("pre_high_result", int'(host.result), 0);
    chk("pre_high_ovf", int'(host.overflow), 0);

    // crossing on the saturation cycle, and one cycle too late
    run_conv(1, 1021, 0, 1'b0, 1'b1, -1, wc);
    chk("edge_result", int'(host.result), 1023);
    chk("edge_ovf", int'(host.overflow), 0);
    run_conv(1, 1022, 0, 1'b0, 1'b1, -1, wc);
    chk("late_result", int'(host.result), 1023);
    chk("late_ovf", int'(host.overflow), 1);

    // continuous with 20 cycles of backpressure
    clr_counts();
    run_conv(5, 30, 20, 1'b1, 1'b1, -1, wc);
    run_conv(3, 10, 0, 1'b0, 1'b0, -1, wc);
    chk("cont_result", int'(host.result), 12);
    chk("cont_single_settle", pwr_n, 64);

    // abort during INTEGRATE, then in DONE together with ready
    run_conv(5, 40, 2, 1'b0, 1'b1, SETTLE + RSTC + 2, wc);
    chk("abort_int_busy", int'(host.busy), 0);
    chk("abort_int_result", int'(host.result), 12);
    run_conv(1, 7, 5, 1'b1, 1'b1, SETTLE + RSTC + 2 + 10 + 2, wc);
    chk("abort_done_valid", int'(host.result_valid), 0);
    chk("abort_done_busy", int'(host.busy), 0);
    chk("abort_done_result", int'(host.result), 9);

    // randomized conversions
    wc = 1'b0;
    for (int n = 0; n < 20; n++) begin
      bit fi;
      fi = !wc;
      il = $urandom_range(0, 12);
      case ($urandom_range(0, 5))
        0:       k = -1;
        1:       k = $urandom_range(1018, 1030);
        default: k = $urandom_range(0, 60);
      endcase
      wr  = $urandom_range(0, 4);
      len = (fi ? SETTLE : 0) + RSTC + il + 1 + ((k < 0) ? 0 : ((k + 2 > MAXC) ? MAXC : k + 2))
            + 1 + wr + 1;
      ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_conv(il, k, wr, bit'($urandom_range(0, 1)), fi, ab, wc);
    end
    if (wc) run_conv(2, 5, 0, 1'b0, 1'b0, -1, wc);
    tick(mk(0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // asynchronous reset in the middle of CONVERT
    host.start = 1'b1; host.int_len = '0; comp_in = 1'b0;
    @(posedge clk); #1 host.start = 1'b0;
    repeat (SETTLE + RSTC + 1 + 20) @(posedge clk);
    #1;
    chk("pre_reset_ramp", int'(ramp_en), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", int'({bias_en, int_rst, int_en, ramp_en, host.busy,
        host.result_valid, host.overflow, host.result}), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_busy", int'(host.busy), 0);
    chk("post_reset_state", int'(state_dbg), int'(IDLE));
    cur_res = '0; cur_ovf = 1'b0;
    run_conv(4, 20, 1, 1'b0, 1'b1, -1, wc);
    chk("post_reset_result", int'(host.result), 22);
    tick(mk(0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rf_readout_sequencer.md
Name: rf_readout_sequencer

Overview:
Sequences the analog RF readout chain (bias/LNA enable, integrator reset, integration window, single-slope ramp conversion) from the digital side of the tile.
It digitizes the readout comparator's ramp-crossing time into a RES_W-bit code and presents it on a valid/ready interface.
It sits between the host-facing config/IO logic and the analog control pins of the readout macro.
It supports single-shot and continuous conversion, plus abort.

Parameters:
RES_W, 10, conversion result width; the ramp counter saturates at 2^RES_W-1.
SETTLE_CYC, 64, bias settle time in clk cycles after power-up (≥1).
RST_CYC, 4, integrator reset pulse length in cycles (≥1).
INT_W, 8, width of the integration length config.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  pulse or level; launches a conversion from IDLE
abort  in  1  forces return to IDLE, highest priority
cont  in  1  continuous mode; sampled when DONE completes
int_len  in  INT_W  integration window is int_len+1 cycles; sampled on entry to INTEGRATE
comp_in  in  1  asynchronous comparator output from the analog ramp comparator
result_ready  in  1  consumer accepts result
bias_en  out  1  analog bias/LNA enable
int_rst  out  1  integrator reset switch
int_en  out  1  integrator enable
ramp_en  out  1  ramp generator enable
busy  out  1  high in any state other than IDLE
result  out  RES_W  captured conversion code
overflow  out  1  ramp reached its maximum without a comparator crossing
result_valid  out  1  result available

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs are 0: bias_en, int_rst, int_en, ramp_en, busy, result, overflow, result_valid. Counters and synchronizer are cleared.
- comp_in passes through a 2-flop synchronizer (comp_s) that runs continuously. Its latency is 2 cycles and is not compensated in the result.
- States and outputs (all outputs registered, Moore):
  - IDLE: all controls 0. On start=1, go to POWERUP. start in any other state is ignored.
  - POWERUP: bias_en=1. Lasts exactly SETTLE_CYC cycles, then RESET_INT.
  - RESET_INT: bias_en=1, int_rst=1. Lasts exactly RST_CYC cycles, then INTEGRATE.
  - INTEGRATE: bias_en=1, int_en=1. Lasts exactly int_len+1 cycles, so int_len=0 gives 1 cycle. Then CONVERT.
  - CONVERT: bias_en=1, int_en=0, ramp_en=1. Counter cnt starts at 0 on the first CONVERT cycle and increments each cycle.
    - In any cycle with comp_s=1: result←cnt, overflow←0, go to DONE.
    - Else if cnt=2^RES_W-1: result←2^RES_W-1, overflow←1, go to DONE.
    - comp_s already 1 on the first CONVERT cycle gives result=0.
  - DONE: bias_en=1, ramp_en=0, result_valid=1. result and overflow are held stable.
    - On result_valid & result_ready: clear result_valid in the next cycle.
    - If cont=1 in the handshake cycle, go to RESET_INT (bias stays on, no re-settle). Otherwise go to IDLE (bias_en drops).
    - Backpressure: DONE is held indefinitely while result_ready=0.
- abort=1 in any state: next state is IDLE. All controls and result_valid are cleared; result and overflow keep their last values. abort beats start and the handshake in the same cycle. abort in IDLE has no effect.
- result and overflow change only on the CONVERT→DONE transition (or on reset).
- busy=1 exactly when state≠IDLE.

Decomposition:
- Shared package rf_readout_pkg:
  - state enum (IDLE, POWERUP, RESET_INT, INTEGRATE, CONVERT, DONE);
  - default constants for RES_W, SETTLE_CYC, RST_CYC, INT_W, shared with the top-level tile wrapper.
- One sub-module: rf_sync2, a 2-flop synchronizer with async active-high reset to 0, used for comp_in.
- The FSM uses a single shared down-counter for the timed states, plus the ramp counter.

Test Plan:
1. Reset mid-CONVERT (rst=1 asynchronously) → all outputs 0 immediately, without waiting for a clk edge. After release, state=IDLE and busy=0.
2. Single shot, SETTLE_CYC=64, RST_CYC=4, int_len=9, comp_in rises 100 cycles into CONVERT → bias_en high for 64 cycles before int_rst, int_rst high for 4 cycles, int_en high for 10 cycles. Then result=102 (crossing plus 2-cycle sync), overflow=0, result_valid=1. After the ready handshake with cont=0: IDLE, bias_en=0.
3. comp_in held low, RES_W=10 → ramp_en high for 1024 cycles, then result=1023, overflow=1, result_valid=1.
4. comp_in held high before conversion → result=0, overflow=0.
5. cont=1, result_ready held 0 for 20 cycles then 1 → result stable for all 20 cycles. Next conversion starts at RESET_INT with no POWERUP, and bias_en never drops.
6. abort asserted during INTEGRATE, and separately in DONE together with result_ready=1 → IDLE the next cycle with result_valid=0 and busy=0. start during busy is ignored: exactly one conversion occurs.
